// File: rtl/button_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter: FSM encodings and the
// default lockout timing.
package button_event_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  localparam int HOLDOFF_DEFAULT = 2_500_000;
  localparam int CNT_W_DEFAULT   = 22;
  localparam int ID_W            = 3;

endpackage

// File: rtl/button_event_arbiter_holdoff_timer.sv
// Per-button lockout timer: loads HOLDOFF on an accepted event, counts down to
// zero and stays there; active while the count is nonzero.
module holdoff_timer
  import button_event_arbiter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic active
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(HOLDOFF);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != '0);

endmodule

// File: rtl/button_event_arbiter.sv
// Latches button pulses, arbitrates round-robin among pending buttons and
// offers one event at a time with a per-button lockout after acceptance.
//
// state    | meaning
// ST_IDLE  | no offer; pick a winner from pending on the next edge
// ST_OFFER | evt_valid=1, evt_id held until evt_ready
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN   = 5,
  parameter int HOLDOFF = HOLDOFF_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic             evt_ready,
  input  logic             ovr_clr,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] overrun
);

  arb_state_e       state_q, state_d;
  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] overrun_q, overrun_d;
  logic [N_BTN-1:0] hold_active;
  logic [N_BTN-1:0] hold_load;
  logic [N_BTN-1:0] pend_shift;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             accept;
  int               idx;

  assign accept = (state_q == ST_OFFER) && evt_ready;

  for (genvar g = 0; g < N_BTN; g++) begin : g_holdoff
    assign hold_load[g] = accept && (evt_id_q == ID_W'(g));

    holdoff_timer #(
      .CNT_W   (CNT_W),
      .HOLDOFF (HOLDOFF)
    ) u_holdoff_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (hold_load[g]),
      .active (hold_active[g])
    );
  end

  // Round-robin search starting one past the last granted button.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
    pend_shift  = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N_BTN) begin
        idx = idx - N_BTN;
      end
      pend_shift = pending_q >> idx;
      if (!grant_found && pend_shift[0]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // Acceptance beats a same-cycle pulse on the accepted button.
  always_comb begin
    pending_d = pending_q;
    overrun_d = ovr_clr ? '0 : overrun_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (hold_load[i]) begin
        pending_d[i] = 1'b0;
      end else if (btn_pulse[i]) begin
        if (pending_q[i]) begin
          overrun_d[i] = 1'b1;
        end else if (!hold_active[i]) begin
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d     = ST_OFFER;
          evt_valid_d = 1'b1;
          evt_id_d    = grant_idx;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          state_d      = ST_IDLE;
          evt_valid_d  = 1'b0;
          last_grant_d = evt_id_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= ID_W'(N_BTN - 1);
      pending_q    <= '0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with a cycle-level reference model
// compared after every clock edge, plus hand-computed scenario checks.
module tb_button_event_arbiter;

  localparam int N  = 5;
  localparam int HO = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_pulse;
  logic         evt_ready;
  logic         ovr_clr;
  logic         evt_valid;
  logic [2:0]   evt_id;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN   (N),
    .HOLDOFF (HO),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pulse (btn_pulse),
    .evt_ready (evt_ready),
    .ovr_clr   (ovr_clr),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  int tests = 0;
  int fails = 0;

  int m_pend[N];
  int m_ovr[N];
  int m_hold[N];
  bit m_offer;
  int m_id;
  int m_last;
  bit model_valid = 1'b0;

  int cyc    = 0;
  int vcount = 0;
  bit prev_v = 1'b0;
  int offers[$];
  int offer_cyc[$];

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [N-1:0] vec(input int a[N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (a[i] != 0);
    return v;
  endfunction

  // Next-state of the reference: what one clock edge must do given the inputs.
  task automatic model_step(input bit r, input logic [N-1:0] b, input bit rdy, input bit clr);
    int np[N];
    int no[N];
    bit acc;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_ovr[i]  = 0;
        m_hold[i] = 0;
      end
      m_offer = 1'b0;
      m_id    = 0;
      m_last  = N - 1;
      return;
    end
    acc = m_offer && rdy;
    for (int i = 0; i < N; i++) begin
      np[i] = m_pend[i];
      no[i] = clr ? 0 : m_ovr[i];
      if (acc && m_id == i) np[i] = 0;
      else if (b[i]) begin
        if (m_pend[i] != 0) no[i] = 1;
        else if (m_hold[i] == 0) np[i] = 1;
      end
      if (acc && m_id == i) m_hold[i] = HO;
      else if (m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
    end
    if (m_offer) begin
      if (rdy) begin
        m_offer = 1'b0;
        m_last  = m_id;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (m_pend[j] != 0) begin
          m_id    = j;
          m_offer = 1'b1;
          break;
        end
      end
    end
    m_pend = np;
    m_ovr  = no;
  endtask

  task automatic step(input bit r, input logic [N-1:0] b, input bit rdy, input bit clr);
    rst       = r;
    btn_pulse = b;
    evt_ready = rdy;
    ovr_clr   = clr;
    model_step(r, b, rdy, clr);
    if (r) model_valid = 1'b1;
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (model_valid) begin
      check("cyc_evt_valid", int'(evt_valid), int'(m_offer));
      if (m_offer) check("cyc_evt_id", int'(evt_id), m_id);
      check("cyc_pending", int'(pending), int'(vec(m_pend)));
      check("cyc_overrun", int'(overrun), int'(vec(m_ovr)));
    end
    if (evt_valid && !prev_v) begin
      offers.push_back(int'(evt_id));
      offer_cyc.push_back(cyc);
    end
    if (evt_valid) vcount++;
    prev_v = evt_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; btn_pulse = '0; evt_ready = 1'b0; ovr_clr = 1'b0;
    @(negedge clk);
    step(1, '0, 0, 0);
    step(1, '0, 0, 0);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_id", int'(evt_id), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_overrun", int'(overrun), 0);

    // single pulse, ready tied high
    step(0, 5'b00100, 1, 0);
    check("s1_lat_pending", int'(pending), 5'b00100);
    check("s1_lat_valid", int'(evt_valid), 0);
    vcount = 0;
    step(0, '0, 1, 0);
    check("s1_valid", int'(evt_valid), 1);
    check("s1_id", int'(evt_id), 2);
    step(0, '0, 1, 0);
    check("s1_valid_drop", int'(evt_valid), 0);
    check("s1_pend_clr", int'(pending), 0);
    repeat (4) step(0, '0, 1, 0);
    check("s1_one_cycle", vcount, 1);

    // three simultaneous pulses after reset
    step(1, '0, 0, 0);
    offers.delete(); offer_cyc.delete();
    step(0, 5'b11001, 1, 0);
    repeat (10) step(0, '0, 1, 0);
    check("s2_n_offers", offers.size(), 3);
    if (offers.size() == 3) begin
      check("s2_first", offers[0], 0);
      check("s2_second", offers[1], 3);
      check("s2_third", offers[2], 4);
      check("s2_gap1", offer_cyc[1] - offer_cyc[0], 2);
      check("s2_gap2", offer_cyc[2] - offer_cyc[1], 2);
    end

    // holdoff discards re-pulses
    step(1, '0, 0, 0);
    step(0, 5'b00010, 1, 0);
    step(0, '0, 1, 0);
    check("s3_offer_id", int'(evt_id), 1);
    step(0, '0, 1, 0);
    step(0, 5'b00010, 1, 0);
    check("s3_disc1", int'(pending), 0);
    step(0, '0, 1, 0);
    step(0, 5'b00010, 1, 0);
    check("s3_disc2", int'(pending), 0);
    step(0, '0, 1, 0);
    step(0, 5'b00010, 1, 0);
    check("s3_reaccept", int'(pending), 5'b00010);
    check("s3_no_ovr", int'(overrun), 0);
    step(0, '0, 1, 0);
    check("s3_reoffer_v", int'(evt_valid), 1);
    check("s3_reoffer_id", int'(evt_id), 1);
    step(0, '0, 1, 0);

    // overrun on a pending button, then clear
    step(1, '0, 0, 0);
    offers.delete();
    step(0, 5'b10000, 0, 0);
    step(0, '0, 0, 0);
    step(0, 5'b10000, 0, 0);
    check("s4_ovr_set", int'(overrun), 5'b10000);
    check("s4_pend", int'(pending), 5'b10000);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    check("s4_accepted", int'(evt_valid), 0);
    repeat (3) step(0, '0, 1, 0);
    check("s4_single_offer", offers.size(), 1);
    step(0, '0, 1, 1);
    check("s4_clr", int'(overrun), 0);
    step(0, 5'b01000, 0, 0);
    step(0, '0, 0, 0);
    step(0, 5'b01000, 0, 1);
    check("s4_clr_race", int'(overrun), 5'b01000);
    step(0, '0, 1, 0);

    // reset mid-offer, priority restored to button 0
    step(1, '0, 0, 0);
    step(0, 5'b01000, 0, 0);
    step(0, '0, 0, 0);
    check("s5_pre_id", int'(evt_id), 3);
    step(1, 5'b00001, 1, 1);
    check("s5_rst_valid", int'(evt_valid), 0);
    check("s5_rst_id", int'(evt_id), 0);
    check("s5_rst_pend", int'(pending), 0);
    check("s5_rst_ovr", int'(overrun), 0);
    step(0, 5'b01001, 1, 0);
    check("s5_pend", int'(pending), 5'b01001);
    step(0, '0, 1, 0);
    check("s5_rr0", int'(evt_id), 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    check("s5_rr3", int'(evt_id), 3);
    step(0, '0, 1, 0);

    // long stall keeps offer and other pending bits stable
    step(1, '0, 0, 0);
    step(0, 5'b01010, 0, 0);
    step(0, '0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      step(0, '0, 0, 0);
      check("s6_id_hold", int'(evt_id), 1);
      check("s6_pend_hold", int'(pending), 5'b01010);
    end
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    check("s6_next_v", int'(evt_valid), 1);
    check("s6_next_id", int'(evt_id), 3);
    repeat (8) step(0, '0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter N_BTN, default 5: number of conditioned button pulse inputs (2..8).
REQ-002 Parameter HOLDOFF, default 2_500_000: per-button lockout length in clk cycles after an event is accepted (>=1).
REQ-003 Parameter CNT_W, default 22: holdoff counter width; SHALL satisfy 2^CNT_W > HOLDOFF.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_pulse  input  N_BTN  one-cycle event pulses from the button conditioning stage, one bit per button.
REQ-007 evt_ready  input  1  consumer accepts the offered event this cycle.
REQ-008 ovr_clr  input  1  clears all overrun flags.
REQ-009 evt_valid  output  1  an event is offered.
REQ-010 evt_id  output  3  index of the offered button; valid only while evt_valid=1.
REQ-011 pending  output  N_BTN  latched, not-yet-accepted events.
REQ-012 overrun  output  N_BTN  sticky flags: a pulse was lost for that button.

Function
REQ-013 pending[i] SHALL set on the clk edge where btn_pulse[i]=1, pending[i]=0 and holdoff[i] is inactive.
REQ-014 A pulse arriving while holdoff[i] is active SHALL be discarded silently, with no flag.
REQ-015 A pulse arriving while pending[i]=1 and not accepted that cycle SHALL be coalesced and SHALL set overrun[i].
REQ-016 Pulse on button i in the same cycle its event is accepted: holdoff wins; the pulse is discarded and pending[i] clears.
REQ-017 FSM states: IDLE and OFFER.
REQ-018 IDLE: if pending != 0, select a winner and go to OFFER; otherwise stay in IDLE.
REQ-019 OFFER: evt_valid=1 and evt_id is held stable until the cycle with evt_ready=1.
REQ-020 Acceptance in OFFER SHALL: clear pending[evt_id], load holdoff[evt_id], record last_grant=evt_id, and return to IDLE.
REQ-021 evt_valid SHALL be 0 in IDLE, which gives at least one idle cycle between consecutive offers.
REQ-022 Arbitration is round-robin: search starts at last_grant+1 and wraps from N_BTN-1 to 0.
REQ-023 Latency: pulse sampled at edge t, pending visible after t, evt_valid=1 after edge t+1 (two cycles pulse-to-offer when idle).
REQ-024 evt_ready while evt_valid=0 SHALL be ignored.
REQ-025 Holdoff counter i: loads HOLDOFF on acceptance, decrements by 1 per cycle, and is active while nonzero.
REQ-026 Holdoff counters SHALL saturate at 0 and never wrap.
REQ-027 ovr_clr SHALL zero all overrun bits; a simultaneous new overrun event on bit i SHALL leave overrun[i]=1.
REQ-028 All outputs are registered; no combinational path from btn_pulse or evt_ready to any output.

Reset
REQ-029 On rst=1 at a clk edge: FSM=IDLE, evt_valid=0, evt_id=0, pending=0, overrun=0, all holdoff counters=0, last_grant=N_BTN-1 (button 0 has first priority).
REQ-030 Reset mid-OFFER SHALL drop the offered event without acceptance side effects.
REQ-031 Reset SHALL have priority over every other input in the same cycle.

Structure
REQ-032 A shared header SHALL hold the FSM state encodings and the default HOLDOFF/CNT_W values.
REQ-033 Sub-module holdoff_timer (load, CNT_W-bit down-counter, active output) SHALL be instantiated N_BTN times.
REQ-034 The round-robin picker is combinational logic inside the top module, feeding registered evt_id.

Verification (N_BTN=5, HOLDOFF=4, CNT_W=3)
REQ-035 Pulse btn 2 at cycle 10, evt_ready tied 1 -> evt_valid=1, evt_id=2 for exactly one cycle starting cycle 12; pending[2] returns to 0.
REQ-036 Pulses on btns 0, 3, 4 in the same cycle, ready=1 -> offers in order 0, 3, 4, each separated by one idle cycle.
REQ-037 Btn 1 accepted at cycle 20, re-pulsed at cycles 21 and 23 -> both pulses discarded; pulse at cycle 25 is accepted and offered.
REQ-038 Btn 4 pending with ready=0, second pulse on btn 4 -> overrun[4]=1 and a single offer; ovr_clr -> overrun[4]=0.
REQ-039 evt_valid=1 with evt_id=3, rst at the next edge -> all outputs zero; after release, btn 0 wins over btn 3 when both pulse together.
REQ-040 Ready held low 10 cycles during an offer -> evt_id stays constant and other pending bits stay set.
